// File: rtl/fifo_sync_param_pkg.sv
// fifo_sync_param_pkg
//   Shared constants and helpers for the parametrised synchronous FIFO:
//   default geometry, default almost-full/almost-empty thresholds and the
//   pointer/index width derivation used by the RTL and its interface.
package fifo_sync_param_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_AE_LEVEL   = 2;

  // Memory index width for a power-of-two depth.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Default almost-full threshold: two entries short of full.
  function automatic int def_af_level(input int depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if
//   Handshake/status bundle of the synchronous FIFO.
//   master : producer/consumer side (drives flush, wr_en, wr_data, rd_en)
//   slave  : FIFO side (drives rd_data, rd_valid, flags, count, pulses)
//   Signals:
//     flush        sync clear of contents, active-high
//     wr_en/wr_data write request and word
//     rd_en        read request
//     rd_data      registered read word, rd_valid marks a fresh pop
//     full/empty/almost_full/almost_empty  status flags
//     count        occupancy 0..DEPTH
//     overflow/underflow  one-cycle rejected-request pulses
interface fifo_sync_param_if
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);
  localparam int CW = addr_width(DEPTH) + 1;

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram_sp.sv
// fifo_ram_sp
//   DEPTH x DATA_WIDTH storage array with one write port and one registered
//   read port.
//   Ports:
//     clk_i    clock
//     rst_ni   async active-low reset (read register only)
//     we_i     write enable, waddr_i/wdata_i
//     re_i     read enable, raddr_i; rdata_o updates the edge after re_i
//                and holds otherwise
module fifo_ram_sp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto RAM/flop arrays
  // without a reset tree; only the visible read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Single-clock parametrised FIFO with pointer/count control, status flags,
//   registered read port, overflow/underflow pulses and synchronous flush.
//   Ports:
//     clk_i   system clock, rising edge
//     rst_ni  async active-low reset
//     bus     fifo_sync_param_if.slave (requests in, data/flags out)
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = def_af_level(DEPTH),
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fifo_sync_param_if.slave  bus
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full, empty;
  logic          wr_acc, rd_acc;

  // Flags come from the registered count, so acceptance below always sees
  // the pre-edge state (full+both -> read wins, empty+both -> write wins).
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign wr_acc = bus.wr_en & ~full  & ~bus.flush;
  assign rd_acc = bus.rd_en & ~empty & ~bus.flush;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + CW'(1);
      if (rd_acc) rptr_d = rptr_q + CW'(1);
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      rd_valid_d  = rd_acc;
      overflow_d  = bus.wr_en & full;
      underflow_d = bus.rd_en & empty;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Read/write addresses can only coincide when empty or full, where one of
  // the two accesses is always rejected, so no collision handling is needed.
  fifo_ram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.wr_data),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (bus.rd_data)
  );

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
//   Directed self-checking bench for fifo_sync_param (DATA_WIDTH=8, DEPTH=8,
//   AF_LEVEL=6, AE_LEVEL=2). Inputs change 1 ns after the rising edge and
//   outputs are sampled at the same point.
module tb_fifo_sync_param;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  fifo_sync_param_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests and return 1 ns after the edge.
  task automatic cycle(input logic we, input logic [7:0] wd,
                       input logic re, input logic fl);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},    32'(bus.count), 0);
    check({tag, "_empty"},    32'(bus.empty), 1);
    check({tag, "_full"},     32'(bus.full), 0);
    check({tag, "_ae"},       32'(bus.almost_empty), 1);
    check({tag, "_af"},       32'(bus.almost_full), 0);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    check({tag, "_rd_data"},  32'(bus.rd_data), 0);
    check({tag, "_ovf"},      32'(bus.overflow), 0);
    check({tag, "_udf"},      32'(bus.underflow), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;

    // Reset state
    #12;
    check_reset_outputs("rst");
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    idle();
    check_reset_outputs("idle");

    // Fill 0x01..0x08 with flag tracking, then drain in order
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_count", 32'(bus.count), 32'(i));
      check("fill_af",    32'(bus.almost_full), (i >= 6) ? 1 : 0);
      check("fill_ae",    32'(bus.almost_empty), (i <= 2) ? 1 : 0);
      check("fill_full",  32'(bus.full), (i == 8) ? 1 : 0);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_valid", 32'(bus.rd_valid), 1);
      check("drain_data",  32'(bus.rd_data), 32'(i));
      check("drain_count", 32'(bus.count), 32'(8 - i));
    end
    idle();
    check("drain_empty",    32'(bus.empty), 1);
    check("drain_valid_lo", 32'(bus.rd_valid), 0);
    check("drain_hold",     32'(bus.rd_data), 32'h08);

    // Overflow on 9th write, underflow on empty read
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_pulse", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 8);
    idle();
    check("ovf_clear", 32'(bus.overflow), 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("ovf_data", 32'(bus.rd_data), 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_pulse", 32'(bus.underflow), 1);
    check("udf_valid", 32'(bus.rd_valid), 0);
    check("udf_hold",  32'(bus.rd_data), 32'h08);
    check("udf_count", 32'(bus.count), 0);
    idle();
    check("udf_clear", 32'(bus.underflow), 0);

    // Wrap-around streaming at occupancy 3
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 8'(8'h13 + k), 1'b1, 1'b0);
      check("wrap_data",  32'(bus.rd_data), 32'(8'h10 + k));
      check("wrap_count", 32'(bus.count), 3);
      check("wrap_valid", 32'(bus.rd_valid), 1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_tail", 32'(bus.rd_data), 32'(8'h24 + i));
    end
    check("wrap_empty", 32'(bus.empty), 1);

    // Full + both: read wins, write rejected
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fb_count", 32'(bus.count), 7);
    check("fb_ovf",   32'(bus.overflow), 1);
    check("fb_valid", 32'(bus.rd_valid), 1);
    check("fb_data",  32'(bus.rd_data), 32'h20);
    for (int i = 1; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("fb_drain", 32'(bus.rd_data), 32'(8'h20 + i));
    end

    // Empty + both: write wins, read rejected
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check("eb_count", 32'(bus.count), 1);
    check("eb_udf",   32'(bus.underflow), 1);
    check("eb_valid", 32'(bus.rd_valid), 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("eb_data",  32'(bus.rd_data), 32'h55);
    check("eb_empty", 32'(bus.empty), 1);

    // Flush beats a simultaneous write and read
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("pre_flush_count", 32'(bus.count), 5);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    check("flush_count", 32'(bus.count), 0);
    check("flush_empty", 32'(bus.empty), 1);
    check("flush_valid", 32'(bus.rd_valid), 0);
    check("flush_hold",  32'(bus.rd_data), 32'h55);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_udf",   32'(bus.underflow), 1);
    cycle(1'b1, 8'h40, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_flush_data", 32'(bus.rd_data), 32'h40);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h63, 1'b1, 1'b0);
    check("mid_data",  32'(bus.rd_data), 32'h60);
    check("mid_count", 32'(bus.count), 3);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h64;
    bus.rd_en   = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_empty", 32'(bus.empty), 1);
    check("post_rst_count", 32'(bus.count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Single-clock, parametrised FIFO with integrated read/write pointer control, occupancy count and status flags. It replaces the fixed 8-entry storage array plus external pointer logic with a self-contained buffer of configurable width and depth. It adds a registered read port, almost-full/almost-empty thresholds, overflow/underflow pulses and a synchronous flush. It sits between the frame/data producers and the UART/serial transmit path in the digital system.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 8, number of entries; power of two, minimum 4
AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL
AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL
(local) ADDR_WIDTH, $clog2(DEPTH), memory index width

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous reset, active-low
FLUSH  in  1  synchronous clear of contents, active-high
WR_EN  in  1  write request
WR_DATA  in  DATA_WIDTH  write word
RD_EN  in  1  read request
RD_DATA  out  DATA_WIDTH  registered read word
RD_VALID  out  1  RD_DATA holds a word popped on the previous edge
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
ALMOST_FULL  out  1  COUNT >= AF_LEVEL
ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
OVERFLOW  out  1  one-cycle pulse: write rejected
UNDERFLOW  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (RST low, asynchronous): write/read pointers 0, COUNT 0, RD_DATA 0, RD_VALID 0, OVERFLOW 0, UNDERFLOW 0. Flags follow: EMPTY 1, FULL 0, ALMOST_EMPTY 1, ALMOST_FULL 0. Memory array is not reset.
- Pointers are ADDR_WIDTH+1 bits. Memory index is the low ADDR_WIDTH bits, so wrap-around is natural modulo DEPTH.
- Flags are decoded combinationally from the registered COUNT. They reflect state after the last edge.
- Write accept = WR_EN & ~FULL: mem[wptr] <= WR_DATA and wptr increments. WR_EN & FULL: no write and OVERFLOW = 1 for the next cycle.
- Read accept = RD_EN & ~EMPTY: RD_DATA <= mem[rptr], rptr increments and RD_VALID = 1 next cycle. Read latency is 1 cycle. RD_DATA holds its value when no read is accepted.
- RD_EN & EMPTY: RD_VALID = 0 and UNDERFLOW = 1 for the next cycle.
- Acceptance uses the pre-edge FULL/EMPTY. Consequences:
  - When full, simultaneous WR_EN and RD_EN: read accepted, write rejected (OVERFLOW), COUNT = DEPTH-1.
  - When empty, simultaneous WR_EN and RD_EN: write accepted, read rejected (UNDERFLOW), COUNT = 1.
  - Otherwise a simultaneous accepted read and write leaves COUNT unchanged.
- COUNT next value = COUNT + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- FLUSH has priority over WR_EN and RD_EN in the same cycle. It sets pointers and COUNT to 0, RD_VALID 0, OVERFLOW 0, UNDERFLOW 0. RD_DATA holds its value. Memory contents are not cleared.
- Reset asserted mid-operation clears everything immediately. Data in flight is lost.

Decomposition:
- Shared package/header: ADDR_WIDTH derivation ($clog2) and the default threshold constants.
- Natural sub-module: fifo_ram_sp, a DEPTH x DATA_WIDTH array with write-enable and registered read-enable, no reset.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Reset, then idle -> EMPTY=1, ALMOST_EMPTY=1, COUNT=0, RD_VALID=0, RD_DATA=0.
- Write 0x01..0x08 (DEPTH=8), then read 8 -> FULL=1 at COUNT=8, ALMOST_FULL from COUNT=6; reads return 0x01..0x08 in order, each RD_VALID one cycle after RD_EN; EMPTY=1 at end.
- Write 8, then a 9th write 0xFF -> OVERFLOW pulse, COUNT stays 8; reading 8 words returns 0x01..0x08 with 0xFF absent. Read on empty -> UNDERFLOW pulse, RD_VALID=0.
- Wrap-around: 20 cycles of continuous simultaneous write/read at COUNT=3 -> COUNT stays 3, output sequence matches input delayed by 3 entries across the pointer wrap.
- Full + WR_EN + RD_EN -> COUNT=7, OVERFLOW=1, read word correct. Empty + both -> COUNT=1, UNDERFLOW=1.
- FLUSH with WR_EN=1 at COUNT=5 -> COUNT=0, EMPTY=1, no write stored. Reset asserted mid-burst -> all outputs at reset values asynchronously.
